// File: rtl/ser_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ser_arbiter
// Brief    : Round-robin arbiter feeding one shared serializer. Drops
//            illegal-length words and aborts if the serializer never starts.
// Revision : 1.0 - initial release
// ============================================================================
module ser_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int START_TMO = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REQ-1:0][15:0]  req_data_i,
    input  logic [NUM_REQ-1:0][3:0]   req_mod_i,
    input  logic [NUM_REQ-1:0]        req_val_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [15:0]               ser_data_o,
    output logic [3:0]                ser_data_mod_o,
    output logic                      ser_data_val_o,
    input  logic                      ser_busy_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      drop_o,
    output logic                      timeout_o
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(START_TMO + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(START_TMO - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_last_k;
    logic [c_IDX_W-1:0]   w_pick_k;
    logic [c_IDX_W-1:0]   w_scan;
    logic                 w_pick_vld;
    logic                 w_can_accept;
    logic                 w_legal;
    logic [15:0]          r_data;
    logic [3:0]           r_mod;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_drop;
    logic [c_CNT_W-1:0]   r_tmo_cnt;

    // Scan from farthest to nearest so the nearest valid requester after last_k wins.
    always_comb begin
        w_pick_k   = '0;
        w_pick_vld = 1'b0;
        w_scan     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_scan = c_IDX_W'((int'(r_last_k) + i) % NUM_REQ);
            if (req_val_i[w_scan]) begin
                w_pick_k   = w_scan;
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_can_accept = (r_state == ST_IDLE) && !ser_busy_i && w_pick_vld;
    assign w_legal      = (req_mod_i[w_pick_k] != 4'd1) && (req_mod_i[w_pick_k] != 4'd2);

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
            assign req_ready_o[g] = rst_n_i && w_can_accept && (w_pick_k == c_IDX_W'(g));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        ser_data_val_o = 1'b0;
        busy_o         = 1'b1;
        timeout_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (w_can_accept && w_legal) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ser_data_val_o = 1'b1;
                w_state_nxt    = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (ser_busy_i) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    timeout_o   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!ser_busy_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Illegal words still advance the round-robin pointer so they cannot starve others.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_k  <= c_LAST_RST;
            r_data    <= '0;
            r_mod     <= '0;
            r_grant   <= '0;
            r_drop    <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_drop <= 1'b0;
            if (w_can_accept) begin
                r_last_k <= w_pick_k;
                if (w_legal) begin
                    r_data  <= req_data_i[w_pick_k];
                    r_mod   <= req_mod_i[w_pick_k];
                    r_grant <= req_ready_o;
                end else begin
                    r_drop <= 1'b1;
                end
            end
            if (w_state_nxt == ST_IDLE) begin
                r_grant <= '0;
            end
            if (r_state == ST_WAIT_START) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign ser_data_o     = r_data;
    assign ser_data_mod_o = r_mod;
    assign grant_o        = r_grant;
    assign drop_o         = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_ser_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser_arbiter
// Brief    : Self-checking bench for ser_arbiter against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int START_TMO = 2;
    localparam int BIG       = 1000000000;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0][15:0] req_data;
    logic [NUM_REQ-1:0][3:0]  req_mod;
    logic [NUM_REQ-1:0]       req_val;
    logic [NUM_REQ-1:0]       req_ready;
    logic [15:0]              ser_data;
    logic [3:0]               ser_mod;
    logic                     ser_val;
    logic                     ser_busy;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic                     drop;
    logic                     tmo;

    ser_arbiter #(.NUM_REQ(NUM_REQ), .START_TMO(START_TMO)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_data_i    (req_data),
        .req_mod_i     (req_mod),
        .req_val_i     (req_val),
        .req_ready_o   (req_ready),
        .ser_data_o    (ser_data),
        .ser_data_mod_o(ser_mod),
        .ser_data_val_o(ser_val),
        .ser_busy_i    (ser_busy),
        .grant_o       (grant),
        .busy_o        (busy),
        .drop_o        (drop),
        .timeout_o     (tmo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Pending words per requester and the order in which they were accepted.
    logic [15:0] q_data [NUM_REQ][$];
    logic [3:0]  q_mod  [NUM_REQ][$];
    int          acc_log[$];

    // Transaction-level expectations, expressed in cycle numbers.
    int          m_last, m_owner, m_start, m_end, m_issue, m_drop, m_tmo;
    logic [15:0] m_data;
    logic [3:0]  m_mod;
    int          stub_left;
    bit          never_busy, rand_hold, rand_ext;

    task automatic model_reset();
        m_last    = NUM_REQ - 1;
        m_owner   = 0;
        m_start   = 0;
        m_end     = -1;
        m_issue   = -1;
        m_drop    = -1;
        m_tmo     = -1;
        m_data    = '0;
        m_mod     = '0;
        stub_left = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            q_data[r].delete();
            q_mod[r].delete();
        end
    endtask

    task automatic push_req(input int r, input logic [15:0] d, input logic [3:0] m);
        q_data[r].push_back(d);
        q_mod[r].push_back(m);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives the pending words, plays the serializer, and checks every cycle.
    task automatic run_traffic(input int max_cyc);
        int budget;
        int pick;
        int acc;
        int k;
        int len;
        bit act;
        bit empty;
        logic [NUM_REQ-1:0] hold;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] rdy_s;
        logic               sdv_s;
        budget = 0;
        forever begin
            @(negedge clk);
            act  = (cyc >= m_start) && (cyc <= m_end);
            hold = rand_hold ? (4'($urandom) & 4'($urandom)) : '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                req_val[r]  = (q_data[r].size() > 0) && !hold[r];
                req_data[r] = (q_data[r].size() > 0) ? q_data[r][0] : 16'($urandom);
                req_mod[r]  = (q_mod[r].size() > 0) ? q_mod[r][0] : 4'($urandom);
            end
            if (stub_left > 0)
                ser_busy = 1'b1;
            else if (rand_ext && !act)
                ser_busy = ($urandom_range(0, 3) == 0);
            else
                ser_busy = 1'b0;
            #1;
            exp_rdy = '0;
            pick    = -1;
            if (!act && !ser_busy) begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    k = (m_last + i) % NUM_REQ;
                    if (pick < 0 && req_val[k]) pick = k;
                end
                if (pick >= 0) exp_rdy[pick] = 1'b1;
            end
            exp_gnt = '0;
            if (act) exp_gnt[m_owner] = 1'b1;

            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
            end
            checks++;
            if (ser_val !== (cyc == m_issue)) begin
                failures++;
                $display("FAIL ser_data_val cyc=%0d: got %b expected %b", cyc, ser_val, (cyc == m_issue));
            end
            checks++;
            if (grant !== exp_gnt) begin
                failures++;
                $display("FAIL grant cyc=%0d: got %b expected %b", cyc, grant, exp_gnt);
            end
            checks++;
            if (busy !== act) begin
                failures++;
                $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, act);
            end
            checks++;
            if (drop !== (cyc == m_drop)) begin
                failures++;
                $display("FAIL drop cyc=%0d: got %b expected %b", cyc, drop, (cyc == m_drop));
            end
            checks++;
            if (tmo !== (cyc == m_tmo)) begin
                failures++;
                $display("FAIL timeout cyc=%0d: got %b expected %b", cyc, tmo, (cyc == m_tmo));
            end
            checks++;
            if (ser_data !== m_data || ser_mod !== m_mod) begin
                failures++;
                $display("FAIL word cyc=%0d: got %h/%0d expected %h/%0d", cyc, ser_data, ser_mod, m_data, m_mod);
            end
            rdy_s = req_ready;
            sdv_s = ser_val;

            @(posedge clk);
            acc = -1;
            for (int r = 0; r < NUM_REQ; r++)
                if (rdy_s[r] && req_val[r]) acc = r;
            if (acc >= 0) begin
                acc_log.push_back(acc);
                m_last = acc;
                if (q_mod[acc][0] == 4'd1 || q_mod[acc][0] == 4'd2) begin
                    m_drop = cyc + 1;
                end else begin
                    m_data  = q_data[acc][0];
                    m_mod   = q_mod[acc][0];
                    m_owner = acc;
                    m_start = cyc + 1;
                    m_issue = cyc + 1;
                    m_end   = never_busy ? cyc + 1 + START_TMO : BIG;
                    m_tmo   = never_busy ? cyc + 1 + START_TMO : -1;
                end
                void'(q_data[acc].pop_front());
                void'(q_mod[acc].pop_front());
            end
            if (sdv_s && !never_busy) begin
                len       = $urandom_range(1, 4);
                stub_left = len;
                m_end     = cyc + 1 + len;
            end else if (stub_left > 0) begin
                stub_left--;
            end
            cyc++;
            budget++;
            empty = 1'b1;
            for (int r = 0; r < NUM_REQ; r++)
                if (q_data[r].size() > 0) empty = 1'b0;
            if (empty && cyc > m_end + 1 && cyc > m_drop + 1) break;
            if (budget >= max_cyc) begin
                checks++;
                failures++;
                $display("FAIL traffic_budget: got %0d cycles expected at most %0d", budget, max_cyc);
                break;
            end
        end
        req_val  = '0;
        ser_busy = 1'b0;
    endtask

    task automatic test_reset();
        req_val  = '1;
        req_mod  = '0;
        req_data = '0;
        ser_busy = 1'b0;
        rst_n    = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || ser_val !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b val=%b gnt=%b busy=%b expected all 0", req_ready, ser_val, grant, busy);
        end
        checks++;
        if (ser_data !== 16'h0 || ser_mod !== 4'h0 || drop !== 1'b0 || tmo !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h drop=%b tmo=%b expected 0", ser_data, ser_mod, drop, tmo);
        end
        req_val = '0;
        model_reset();
        release_reset();
    endtask

    task automatic test_single();
        acc_log.delete();
        push_req(0, 16'hA5C3, 4'd0);
        run_traffic(50);
        checks++;
        if (acc_log.size() != 1 || acc_log[0] != 0) begin
            failures++;
            $display("FAIL single_grant: got %0d accepts expected one from requester 0", acc_log.size());
        end
        checks++;
        if (ser_data !== 16'hA5C3 || ser_mod !== 4'd0) begin
            failures++;
            $display("FAIL single_hold: got %h/%0d expected a5c3/0", ser_data, ser_mod);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        release_reset();
        acc_log.delete();
        push_req(0, 16'h1000, 4'd8);
        push_req(0, 16'h1001, 4'd8);
        push_req(1, 16'h2000, 4'd8);
        push_req(2, 16'h3000, 4'd8);
        push_req(3, 16'h4000, 4'd8);
        run_traffic(200);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (acc_log.size() <= i || acc_log[i] != exp_order[i]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i,
                         (acc_log.size() > i) ? acc_log[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_drop();
        acc_log.delete();
        push_req(2, 16'hDEAD, 4'd1);
        push_req(3, 16'hBEEF, 4'd4);
        run_traffic(50);
        checks++;
        if (acc_log.size() != 2 || acc_log[0] != 2 || acc_log[1] != 3) begin
            failures++;
            $display("FAIL drop_order: got %0d accepts expected requesters 2 then 3", acc_log.size());
        end
        checks++;
        if (ser_data !== 16'hBEEF || ser_mod !== 4'd4) begin
            failures++;
            $display("FAIL drop_word: got %h/%0d expected beef/4", ser_data, ser_mod);
        end
    endtask

    task automatic test_timeout();
        acc_log.delete();
        never_busy = 1'b1;
        push_req(0, 16'h0F0F, 4'd5);
        push_req(1, 16'h7777, 4'd12);
        run_traffic(50);
        never_busy = 1'b0;
        checks++;
        if (acc_log.size() != 2 || acc_log[1] != 1) begin
            failures++;
            $display("FAIL timeout_next: got %0d accepts expected 2 ending with requester 1", acc_log.size());
        end
    endtask

    task automatic test_random();
        acc_log.delete();
        rand_hold = 1'b1;
        rand_ext  = 1'b1;
        for (int i = 0; i < 30; i++)
            push_req($urandom_range(0, NUM_REQ - 1), 16'($urandom), 4'($urandom_range(0, 15)));
        run_traffic(3000);
        rand_hold = 1'b0;
        rand_ext  = 1'b0;
        checks++;
        if (acc_log.size() != 30) begin
            failures++;
            $display("FAIL random_count: got %0d accepts expected 30", acc_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        @(negedge clk);
        req_val     = 4'b0010;
        req_data[1] = 16'h5A5A;
        req_mod[1]  = 4'd6;
        ser_busy    = 1'b0;
        waited      = 0;
        #1;
        while (req_ready !== 4'b0010 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_accept: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_val  = '0;
        ser_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0010) begin
            failures++;
            $display("FAIL mid_active: got busy=%b gnt=%b expected 1/0010", busy, grant);
        end
        req_val = 4'b0011;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== '0 || req_ready !== '0 || ser_val !== 1'b0 || ser_data !== 16'h0 || ser_mod !== 4'h0) begin
            failures++;
            $display("FAIL mid_reset: got busy=%b gnt=%b rdy=%b val=%b word=%h/%h expected all 0",
                     busy, grant, req_ready, ser_val, ser_data, ser_mod);
        end
        req_val  = '0;
        ser_busy = 1'b0;
        model_reset();
        release_reset();
        acc_log.delete();
        push_req(1, 16'h1111, 4'd7);
        push_req(0, 16'h0000, 4'd3);
        run_traffic(50);
        checks++;
        if (acc_log.size() != 2 || acc_log[0] != 0 || acc_log[1] != 1) begin
            failures++;
            $display("FAIL mid_restart: got %0d accepts expected requester 0 then 1", acc_log.size());
        end
    endtask

    initial begin
        never_busy = 1'b0;
        rand_hold  = 1'b0;
        rand_ext   = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one serializer (2..8).
REQ-002 SHALL have parameter START_TMO, default 2, max cycles in WAIT_START before abort.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_data_i  input  NUM_REQ x 16  per-requester parallel word, MSB sent first.
REQ-006 SHALL have port req_mod_i  input  NUM_REQ x 4  per-requester length: 0 = 16 bits, 3..15 = that many bits, 1/2 = illegal.
REQ-007 SHALL have port req_val_i  input  NUM_REQ  per-requester valid; held until accepted.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  accept strobe; transfer when val and ready both high.
REQ-009 SHALL have port ser_data_o  output  16  word to serializer data_i.
REQ-010 SHALL have port ser_data_mod_o  output  4  length to serializer data_mod_i.
REQ-011 SHALL have port ser_data_val_o  output  1  start strobe to serializer data_val_i.
REQ-012 SHALL have port ser_busy_i  input  1  serializer busy_o.
REQ-013 SHALL have port grant_o  output  NUM_REQ  one-hot owner of current transaction.
REQ-014 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port drop_o  output  1  one-cycle pulse: illegal-length request consumed.
REQ-016 SHALL have port timeout_o  output  1  one-cycle pulse: serializer never asserted busy.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-018 In IDLE with ser_busy_i=0 and any req_val_i set, SHALL pick requester k by round-robin, searching from (last_k+1) mod NUM_REQ upward with wrap.
REQ-019 req_ready_o SHALL be combinational: only bit k high, only in IDLE with ser_busy_i=0; all zero otherwise.
REQ-020 On accept of legal k: capture req_data_i[k], req_mod_i[k] into ser_data_o/ser_data_mod_o, set grant_o=onehot(k), last_k=k, go ISSUE.
REQ-021 On accept of illegal k (mod 1 or 2): no capture, drop_o=1 next cycle, last_k=k, stay IDLE.
REQ-022 ISSUE SHALL last exactly 1 cycle with ser_data_val_o=1, then go WAIT_START; ser_data_val_o=0 in every other state.
REQ-023 WAIT_START: ser_busy_i=1 -> WAIT_DONE; after START_TMO cycles without busy -> IDLE with timeout_o pulse.
REQ-024 WAIT_DONE: ser_busy_i=0 -> IDLE.
REQ-025 Latency: accept in cycle N -> ser_data_val_o high in cycle N+1.
REQ-026 ser_data_o/ser_data_mod_o SHALL hold last captured value until next legal accept.
REQ-027 grant_o SHALL be zero in IDLE, onehot(k) in ISSUE/WAIT_START/WAIT_DONE.
REQ-028 New requests arriving while not IDLE SHALL wait; requester deasserting val before accept SHALL lose nothing and cause no transaction.
REQ-029 ser_busy_i=1 in IDLE (external use) SHALL block all accepts.
REQ-030 Only one accept per cycle; at most one transaction outstanding.

Reset
REQ-031 rst_n_i low SHALL force IDLE, last_k=NUM_REQ-1 (requester 0 first), all outputs 0, immediately without clock.
REQ-032 Reset mid-transaction SHALL abandon it; after release arbitration restarts from requester 0.

Verification
REQ-033 Single req0, data 16'hA5C3, mod 0 -> ready[0] one cycle, next cycle ser_data_val_o=1 with 16'hA5C3/0, grant_o=0001 until busy falls.
REQ-034 All four valid continuously, mod 8 -> grants in order 0,1,2,3,0, each waits for serializer busy to fall.
REQ-035 req2 mod 1, req3 mod 4 -> req2 consumed with drop_o pulse and no ser_data_val_o; then req3 issued with mod 4.
REQ-036 Serializer stub never asserts busy -> ser_data_val_o pulse, timeout_o pulse 2 cycles later, back to IDLE, next request served.
REQ-037 rst_n_i low during WAIT_DONE of req1 -> outputs 0 asynchronously; after release with req1 and req0 valid, req0 granted first.
